result_serializer: RTL and testbench
====================================

# result_serializer

Output stage placed directly downstream of the 2x2 systolic array. It captures the four 16-bit accumulations (c00, c01, c10, c11) on a start pulse and streams them to the host as bytes over a valid/ready handshake. It replaces the current path, which exposes only the low 8 bits of one result at a time. It frees the array for the next matrix as soon as capture completes.

## Interface

Parameters:
- LSB_FIRST, default 1: byte order within each 16-bit word. 1 sends the low byte first; 0 sends the high byte first.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  capture request; sampled only in IDLE
- c00, c01, c10, c11  in  16 each  signed two's-complement accumulations from the array
- out_data  out  8  current byte
- out_valid  out  1  out_data holds a valid byte
- out_ready  in  1  host accepts the byte this cycle
- busy  out  1  capture taken, transfer not yet finished
- done  out  1  one-cycle pulse after the last byte is accepted
- sat_flag  out  1  at least one captured value was clipped (saturation build only; otherwise tied 0)

## Operation

- States:
  - IDLE: wait for start.
  - SEND: stream captured bytes.
- Reset values: state=IDLE, all capture registers 0, byte index 0, out_data=0x00, out_valid=0, busy=0, done=0, sat_flag=0.
- IDLE with start=1:
  - Latch c00..c11 into internal registers.
  - Index=0; go to SEND.
  - done is cleared.
- SEND:
  - out_valid=1 and busy=1.
  - out_data is the byte selected by index, registered from the captured values.
  - A handshake is out_valid & out_ready in the same cycle.
  - On a handshake with index < N-1: index increments.
  - On a handshake with index = N-1: go to IDLE, out_valid=0, busy=0, done=1 for exactly one cycle.
- Byte sequence: words in the order c00, c01, c10, c11. Within each word, bytes follow LSB_FIRST. N=8 bytes.
- Boundary conditions:
  - start is ignored in SEND. Captured data does not change.
  - out_ready while out_valid=0 has no effect.
  - out_data is 0x00 whenever out_valid=0.
  - out_data and out_valid are held stable while out_valid=1 and out_ready=0, indefinitely.
  - start in the same cycle as done=1 is accepted (the block is in IDLE).
  - Input changes after capture have no effect on the stream.
  - rst_n low mid-transfer aborts immediately to reset values. No done pulse is generated. The partial stream is discarded.

## Timing

- start sampled high at edge k gives out_valid=1 and the first byte on out_data after edge k.
- With out_ready held high: one byte per cycle. The last handshake is at edge k+N, and done=1 for the cycle after it (k+N to k+N+1).
- Minimum start-to-start spacing is N+1 cycles.
- Each cycle with out_valid=1 and out_ready=0 adds one cycle.
- busy equals out_valid.
- There are no combinational paths from inputs to outputs.

## Configuration

Macro RESULT_SAT8_EN:
- Defined:
  - Each word is saturated to signed 8-bit at capture: values >127 become 0x7F, values <-128 become 0x80, all others are the low byte.
  - N=4; LSB_FIRST is ignored.
  - sat_flag is set at capture if any of the four words clipped. It holds until the next capture or reset.
- Not defined:
  - Full 16-bit words are sent, N=8.
  - sat_flag is constant 0.

## Test plan

- Basic stream, 16-bit build, LSB_FIRST=1, out_ready=1, inputs c00=0x1234, c01=0xABCD, c10=0x0001, c11=0xFFFF, start pulsed -> bytes 34 12 CD AB 01 00 FF FF on consecutive cycles, then done=1 for one cycle and busy=0.
- Same inputs with LSB_FIRST=0 -> 12 34 AB CD 00 01 FF FF.
- Backpressure: drop out_ready for 3 cycles on byte 2 -> out_data holds 0xCD across those cycles, no byte is skipped or duplicated, and done is delayed by 3 cycles.
- start pulsed in SEND with different c inputs -> ignored; the original 8 bytes complete unchanged. start on the done cycle -> a new capture, and the first byte appears on the next cycle.
- Reset mid-stream: assert rst_n=0 after byte 3 -> out_valid, busy, done, out_data are 0 immediately. A subsequent start streams a fresh capture from byte 0.
- RESULT_SAT8_EN build, inputs c00=300, c01=-200 (0xFF38), c10=5, c11=-3 -> bytes 7F 80 05 FD, then done, sat_flag=1. Next capture with all values in range -> sat_flag=0.

Source files
------------

// File: rtl/result_serializer.sv
// Captures the four 2x2 array accumulations on start and streams them out as bytes over valid/ready.
// Build option RESULT_SAT8_EN: clip each word to signed 8 bits at capture and send 4 bytes instead of 8.
module result_serializer #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [15:0] c00,
  input  logic signed [15:0] c01,
  input  logic signed [15:0] c10,
  input  logic signed [15:0] c11,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               sat_flag
);

`ifdef RESULT_SAT8_EN
  localparam int N = 4;
`else
  localparam int N = 8;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [2:0]  idx;
  logic [63:0] cap;
  logic [63:0] cap_in;
  logic        clip_in;
  logic        cap_en, adv, last;

  function automatic logic [7:0] sat8(input logic signed [15:0] v);
    if (v > 16'sd127)       return 8'h7F;
    else if (v < -16'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  function automatic logic is_clip(input logic signed [15:0] v);
    return (v > 16'sd127) || (v < -16'sd128);
  endfunction

  // Word j lives at cap[16*j +: 16]; in the 8-bit build only its low byte is meaningful.
  function automatic logic [7:0] sel_byte(input logic [63:0] w, input logic [2:0] i);
`ifdef RESULT_SAT8_EN
    return w[{i[1:0], 4'b0000} +: 8];
`else
    logic hi;
    hi = LSB_FIRST ? i[0] : ~i[0];
    return w[{i[2:1], hi, 3'b000} +: 8];
`endif
  endfunction

  always_comb begin
`ifdef RESULT_SAT8_EN
    cap_in  = {8'h00, sat8(c11), 8'h00, sat8(c10), 8'h00, sat8(c01), 8'h00, sat8(c00)};
    clip_in = is_clip(c00) | is_clip(c01) | is_clip(c10) | is_clip(c11);
`else
    cap_in  = {c11, c10, c01, c00};
    clip_in = 1'b0;
`endif
  end

  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    adv       = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cap_en    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx == 3'(N - 1)) begin
            last      = 1'b1;
            state_nxt = IDLE;
          end else begin
            adv = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cap      <= 64'd0;
      out_data <= 8'h00;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= last;
      // out_data is preloaded one step ahead so the byte is valid the cycle SEND is entered.
      if (cap_en) begin
        cap      <= cap_in;
        idx      <= 3'd0;
        out_data <= sel_byte(cap_in, 3'd0);
        sat_flag <= clip_in;
      end else if (adv) begin
        idx      <= idx + 3'd1;
        out_data <= sel_byte(cap, idx + 3'd1);
      end else if (last) begin
        idx      <= 3'd0;
        out_data <= 8'h00;
      end
    end
  end

  assign out_valid = (state == SEND);
  assign busy      = (state == SEND);

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: two instances (low-byte-first and high-byte-first) share all inputs.
module tb_result_serializer;

`ifdef RESULT_SAT8_EN
  localparam int NB = 4;
  localparam logic [63:0] E1_BASIC = 64'h7F8001FF_00000000;
  localparam logic [63:0] E0_BASIC = 64'h7F8001FF_00000000;
  localparam logic [63:0] E1_NEW   = 64'h7F807F7F_00000000;
  localparam logic [63:0] E0_NEW   = 64'h7F807F7F_00000000;
  localparam logic [63:0] E1_FRESH = 64'h7F7F7F7F_00000000;
  localparam logic [63:0] E0_FRESH = 64'h7F7F7F7F_00000000;
`else
  localparam int NB = 8;
  localparam logic [63:0] E1_BASIC = 64'h3412CDAB_0100FFFF;
  localparam logic [63:0] E0_BASIC = 64'h1234ABCD_0001FFFF;
  localparam logic [63:0] E1_NEW   = 64'h66550080_FF7FA500;
  localparam logic [63:0] E0_NEW   = 64'h55668000_7FFF00A5;
  localparam logic [63:0] E1_FRESH = 64'h02010403_06050807;
  localparam logic [63:0] E0_FRESH = 64'h01020304_05060708;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic signed [15:0] c00 = '0, c01 = '0, c10 = '0, c11 = '0;

  logic [7:0] l_data, m_data;
  logic l_valid, l_busy, l_done, l_sat;
  logic m_valid, m_busy, m_done, m_sat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  result_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_data(l_data), .out_valid(l_valid), .out_ready(out_ready),
    .busy(l_busy), .done(l_done), .sat_flag(l_sat)
  );

  result_serializer #(.LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .out_data(m_data), .out_valid(m_valid), .out_ready(out_ready),
    .busy(m_busy), .done(m_done), .sat_flag(m_sat)
  );

  function automatic logic [7:0] b8(input logic b);
    return {7'd0, b};
  endfunction

  function automatic logic [7:0] bsel(input logic [63:0] e, input int i);
    return e[63 - 8*i -: 8];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
    c00 = a; c01 = b; c10 = c; c11 = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Entered one step after the capture edge; leaves on the done cycle.
  task automatic play(input logic [63:0] e1, input logic [63:0] e0,
                      input int stall_at, input int stall_n, input int inject_at);
    for (int i = 0; i < NB; i++) begin
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          chk("stall_data", l_data, bsel(e1, i));
          chk("stall_valid", b8(l_valid), 8'd1);
          chk("stall_done", b8(l_done), 8'd0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
      if (i == inject_at) begin
        start = 1'b1;
        c00 = 16'shDEAD; c01 = 16'shDEAD; c10 = 16'shDEAD; c11 = 16'shDEAD;
      end
      chk("byte_lsb", l_data, bsel(e1, i));
      chk("byte_msb", m_data, bsel(e0, i));
      chk("send_valid", b8(l_valid), 8'd1);
      chk("send_busy", b8(l_busy), 8'd1);
      chk("send_done", b8(l_done), 8'd0);
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("done_pulse", b8(l_done), 8'd1);
    chk("done_pulse_msb", b8(m_done), 8'd1);
    chk("end_valid", b8(l_valid), 8'd0);
    chk("end_busy", b8(l_busy), 8'd0);
    chk("end_data", l_data, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", b8(l_valid), 8'd0);
    chk("rst_busy", b8(l_busy), 8'd0);
    chk("rst_done", b8(l_done), 8'd0);
    chk("rst_data", l_data, 8'h00);
    chk("rst_sat", b8(l_sat), 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // out_ready while idle must not produce anything
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready_valid", b8(l_valid), 8'd0);
    chk("idle_ready_data", l_data, 8'h00);

    // basic stream, both byte orders
    capture(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    play(E1_BASIC, E0_BASIC, -1, 0, -1);
    @(posedge clk); #1;
    chk("done_one_cycle", b8(l_done), 8'd0);

    // backpressure on byte 2 for three cycles
    capture(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    play(E1_BASIC, E0_BASIC, 2, 3, -1);

    // start during SEND is ignored, then start on the done cycle is accepted
    @(posedge clk); #1;
    capture(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    play(E1_BASIC, E0_BASIC, -1, 0, 3);
    capture(16'h5566, 16'h8000, 16'h7FFF, 16'h00A5);
    chk("restart_done_clear", b8(l_done), 8'd0);
    play(E1_NEW, E0_NEW, -1, 0, -1);

    // reset mid-stream after three bytes accepted
    @(posedge clk); #1;
    capture(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_byte3", l_data, bsel(E1_BASIC, 3));
    rst_n = 1'b0;
    #1;
    chk("abort_valid", b8(l_valid), 8'd0);
    chk("abort_busy", b8(l_busy), 8'd0);
    chk("abort_done", b8(l_done), 8'd0);
    chk("abort_data", l_data, 8'h00);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_done", b8(l_done), 8'd0);
    chk("post_rst_valid", b8(l_valid), 8'd0);
    capture(16'h0102, 16'h0304, 16'h0506, 16'h0708);
    play(E1_FRESH, E0_FRESH, -1, 0, -1);

`ifdef RESULT_SAT8_EN
    @(posedge clk); #1;
    capture(16'd300, 16'hFF38, 16'd5, 16'hFFFD);
    chk("sat_flag_set", b8(l_sat), 8'd1);
    play(64'h7F8005FD_00000000, 64'h7F8005FD_00000000, -1, 0, -1);
    chk("sat_flag_hold", b8(l_sat), 8'd1);
    capture(16'd1, 16'd2, 16'hFFFE, 16'd127);
    chk("sat_flag_clear", b8(l_sat), 8'd0);
    play(64'h0102FE7F_00000000, 64'h0102FE7F_00000000, -1, 0, -1);
`else
    chk("sat_flag_tied", b8(l_sat), 8'd0);
    chk("sat_flag_tied_msb", b8(m_sat), 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
